calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter N, default 6, giving the row/column dimension of the operand matrices.
REQ-002 SHALL have parameter W, default 32, giving the operand, product and result width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a pulse that begins one N*N dot-product job.
REQ-006 SHALL have port a_in, input, W, the a operand of the current element pair.
REQ-007 SHALL have port b_in, input, W, the b operand of the current element pair.
REQ-008 SHALL have port in_valid, input, 1, meaning the a_in/b_in pair is valid.
REQ-009 SHALL have port in_ready, output, 1, meaning the block accepts a pair this cycle.
REQ-010 SHALL have port row, output, 3, the row index of the next expected pair.
REQ-011 SHALL have port col, output, 3, the column index of the next expected pair.
REQ-012 SHALL have port F, output, W, the accumulated result.
REQ-013 SHALL have port out_valid, output, 1, meaning F holds a completed result.
REQ-014 SHALL have port out_ready, input, 1, the consumer's acceptance of F.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL go from IDLE to RUN on start and, on that edge, clear the accumulator, the element counter and the product-valid flag.
REQ-018 SHALL ignore start in RUN, DRAIN and DONE.
REQ-019 SHALL drive in_ready=1 only in RUN; a pair is accepted on any edge where in_valid and in_ready are both 1.
REQ-020 SHALL treat in_valid gaps as stalls; the counter, row/col and accumulator SHALL hold during a gap.
REQ-021 SHALL use a two-stage pipeline: stage 1 registers the low W bits of a_in*b_in on acceptance; stage 2 adds the registered product into the accumulator on the following edge.
REQ-022 SHALL perform all additions modulo 2^W, with no saturation and no overflow flag.
REQ-023 SHALL present row/col as the row-major index of the next expected pair: col increments, and wraps at N-1 to 0 while row increments.
REQ-024 SHALL go from RUN to DRAIN on the edge that accepts the N*N-th pair, with in_ready=0 from the next cycle.
REQ-025 SHALL stay in DRAIN for exactly one cycle, while the last product accumulates, then go to DONE.
REQ-026 SHALL drive out_valid=1 and F equal to the accumulator in DONE, both held stable until out_ready=1.
REQ-027 SHALL go from DONE to IDLE on the edge where out_valid and out_ready are both 1.
REQ-028 SHALL have latency from last-pair acceptance to out_valid of exactly 2 cycles.
REQ-029 SHALL drive out_valid=0, and F equal to the last accumulator value, outside DONE.
REQ-030 SHALL, when start and out_ready coincide in DONE, complete the handshake only; start is ignored.

Reset
REQ-031 SHALL, while rst_n=0, immediately force state=IDLE, accumulator=0, product register=0, counter=0, row=0, col=0, F=0, in_ready=0, out_valid=0 and busy=0.
REQ-032 SHALL discard an in-progress job when reset is asserted mid-job; no partial result SHALL be emitted.
REQ-033 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-034 SHALL place the state enumeration and the N, W and COUNT=N*N constants in the shared package calc_pkg.
REQ-035 SHALL instantiate exactly one multiply and one fulladd from the existing library, time-shared across all N*N pairs.
REQ-036 SHALL use calc_ctrl as its only new module; no further sub-module is needed.

Verification
REQ-037 SHALL cover: start, then 36 pairs a=1, b=1 back-to-back -> out_valid exactly 2 cycles after the last acceptance, F=36.
REQ-038 SHALL cover: pairs a=k, b=1 for k=0..35 with random in_valid gaps -> F=630, and row/col stepping (0,0)..(5,5) only on acceptance.
REQ-039 SHALL cover: 36 pairs a=32'hFFFF_FFFF, b=1 -> F=32'hFFFF_FFDC (wrap-around).
REQ-040 SHALL cover: out_ready held 0 for 5 cycles in DONE, with start pulsed -> F and out_valid stable, no new job, IDLE after out_ready.
REQ-041 SHALL cover: rst_n pulsed low after 10 accepted pairs -> all outputs 0 immediately; a new job of all a=2, b=3 -> F=216.
REQ-042 SHALL cover: in_valid=1 held while in DRAIN/DONE -> no extra pair accepted, count remains 36.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calc_ctrl dot-product controller.
package calc_pkg;

  localparam int unsigned N     = 6;
  localparam int unsigned W     = 32;
  localparam int unsigned COUNT = N * N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fulladd.sv
// Library adder: W-bit sum modulo 2^W, carry out discarded.
module fulladd #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  // Modulo 2^W addition
  always_comb begin
    s = a + b;
  end

endmodule

// File: rtl/multiply.sv
// Library multiplier: low W bits of a*b, purely combinational.
module multiply #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  // W-bit context truncates the product to its low W bits
  always_comb begin
    p = a * b;
  end

endmodule

// File: rtl/calc_ctrl.sv
// N*N dot-product controller: one shared multiply and fulladd, two-stage
// pipeline (product register, then accumulate), result held until consumed.
module calc_ctrl #(
  parameter int unsigned N = calc_pkg::N,
  parameter int unsigned W = calc_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [2:0]   row,
  output logic [2:0]   col,
  output logic [W-1:0] F,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  import calc_pkg::*;

  localparam int unsigned JOB_LEN = N * N;
  localparam int unsigned CW      = $clog2(JOB_LEN + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   prod_q, prod_d;
  logic           prod_vld_q, prod_vld_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     row_q, row_d;
  logic [2:0]     col_q, col_d;

  logic [W-1:0]   mul_p;
  logic [W-1:0]   sum;
  logic           accept;
  logic           last;

  multiply #(.W(W)) u_multiply (
    .a (a_in),
    .b (b_in),
    .p (mul_p)
  );

  fulladd #(.W(W)) u_fulladd (
    .a (acc_q),
    .b (prod_q),
    .s (sum)
  );

  // Handshake and status outputs decoded from the state register
  always_comb begin
    in_ready  = (state_q == RUN);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    F         = acc_q;
    row       = row_q;
    col       = col_q;
  end

  // Next-state, pipeline and index computation
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;

    accept = (state_q == RUN) && in_valid;
    last   = (cnt_q == CW'(JOB_LEN - 1));

    // Stage 2: fold the product registered on the previous acceptance
    if (prod_vld_q) begin
      acc_d = sum;
    end

    // Stage 1: register the product and advance the row-major index
    if (accept) begin
      prod_d     = mul_p;
      prod_vld_d = 1'b1;
      cnt_d      = cnt_q + CW'(1);
      if (col_q == 3'(N - 1)) begin
        col_d = '0;
        row_d = (row_q == 3'(N - 1)) ? '0 : row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          acc_d      = '0;
          cnt_d      = '0;
          prod_vld_d = 1'b0;
          row_d      = '0;
          col_d      = '0;
        end
      end
      RUN: begin
        if (accept && last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: expected results are queued as jobs are
// issued and popped by a monitor whenever a result handshake is presented.
module tb_calc_ctrl;

  localparam int unsigned N   = 6;
  localparam int unsigned W   = 32;
  localparam int unsigned CNT = N * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   row;
  logic [2:0]   col;
  logic [W-1:0] F;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  calc_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row       (row),
    .col       (col),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every presented result handshake must match the oldest queued job
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_F", F, e);
      end
    end
  end

  // mode: 0 a=1,b=1; 1 a=k,b=1; 2 a=all-ones,b=1; 3 a=2,b=3; else random
  task automatic run_job(input int mode, input int gap_pct, input bit hold_valid,
                         input int abort_after, input bit hold_done);
    logic [W-1:0] a_arr[CNT];
    logic [W-1:0] b_arr[CNT];
    logic [W-1:0] model;
    logic [63:0]  p;
    int           guard;
    model = '0;
    for (int k = 0; k < int'(CNT); k++) begin
      case (mode)
        0:       begin a_arr[k] = 1;          b_arr[k] = 1; end
        1:       begin a_arr[k] = k;          b_arr[k] = 1; end
        2:       begin a_arr[k] = 32'hFFFF_FFFF; b_arr[k] = 1; end
        3:       begin a_arr[k] = 2;          b_arr[k] = 3; end
        default: begin a_arr[k] = $urandom;   b_arr[k] = $urandom; end
      endcase
      p = 64'(a_arr[k]) * 64'(b_arr[k]);
      model = model + p[W-1:0];
    end
    exp_q.push_back(model);
    out_ready = !hold_done;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);

    for (int k = 0; k < int'(CNT); k++) begin
      if (abort_after == k) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_F", F, 0);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        @(negedge clk);
        check("gap_row", row, k / N);
        check("gap_col", col, k % N);
        @(posedge clk); #1;
      end
      a_in = a_arr[k];
      b_in = b_arr[k];
      in_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      check("row", row, k / N);
      check("col", col, k % N);
      @(posedge clk); #1;
    end

    // Past the last pair: optionally keep offering data that must be refused
    in_valid = hold_valid;
    a_in = $urandom;
    b_in = 1;
    @(negedge clk);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check("done_F", F, model);

    if (hold_done) begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        check("hold_out_valid", out_valid, 1);
        check("hold_F", F, model);
        check("hold_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_F", F, model);
    @(posedge clk); #1;
    check("idle_stays", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_F", F, 0);
    check("reset_row", row, 0);
    check("reset_col", col, 0);
    rst_n = 1'b1;

    run_job(0, 0, 1'b1, -1, 1'b0);   // a=1,b=1 back-to-back -> 36
    run_job(1, 40, 1'b0, -1, 1'b0);  // a=k,b=1 with gaps -> 630
    run_job(2, 0, 1'b0, -1, 1'b0);   // wrap-around -> FFFF_FFDC
    run_job(4, 20, 1'b1, -1, 1'b1);  // result held against out_ready=0
    run_job(3, 0, 1'b0, 10, 1'b0);   // aborted by reset after 10 pairs
    run_job(3, 0, 1'b0, -1, 1'b0);   // restarted job -> 216
    for (int j = 0; j < 3; j++) begin
      run_job(4, 30, 1'b1, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
